// File: rtl/pc_gen_if.sv
// pc_gen control/status bundle.
// Fetch control in, fetch PC and status out.
interface pc_gen_if #(
   parameter int unsigned XLEN = 64
);
   logic            stall_i;
   logic            halt_i;
   logic            redirect_valid_i;
   logic [XLEN-1:0] redirect_target_i;
   logic            trap_valid_i;
   logic [XLEN-1:0] trap_vector_i;
   logic [XLEN-1:0] pc_o;
   logic [XLEN-1:0] pc_plus_inc_o;
   logic            fetch_valid_o;
   logic            misaligned_o;

   modport master (
      output stall_i, halt_i,
      output redirect_valid_i, redirect_target_i,
      output trap_valid_i, trap_vector_i,
      input  pc_o, pc_plus_inc_o,
      input  fetch_valid_o, misaligned_o
   );

   modport slave (
      input  stall_i, halt_i,
      input  redirect_valid_i, redirect_target_i,
      input  trap_valid_i, trap_vector_i,
      output pc_o, pc_plus_inc_o,
      output fetch_valid_o, misaligned_o
   );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator.
// Trap > redirect > pending > hold > sequential.
module pc_gen #(
   parameter int unsigned     XLEN         = 64,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int unsigned     INC          = 4,
   parameter bit              WRAP_EN      = 1'b0,
   parameter logic [XLEN-1:0] WRAP_LIMIT   = XLEN'(64'h40)
) (
   input  logic    clk,
   input  logic    reset,
   pc_gen_if.slave bus
);
   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   localparam logic [XLEN-1:0] LOW_MASK =
      XLEN'(INC) - XLEN'(1);

   state_t          r_state;
   logic [XLEN-1:0] r_pc;
   logic            r_fv;
   logic            r_mis;
   logic            r_pv;
   logic [XLEN-1:0] r_pt;
   logic            r_ptrap;

   state_t          w_state_nxt;
   logic [XLEN-1:0] w_pc_nxt;
   logic            w_mis_nxt;
   logic            w_pv_nxt;
   logic [XLEN-1:0] w_pt_nxt;
   logic            w_ptrap_nxt;
   logic            w_apply;
   logic [XLEN-1:0] w_tgt;
   logic [XLEN-1:0] w_inc;
   logic [XLEN-1:0] w_seq;
   logic            w_frozen;

   assign w_inc = r_pc + XLEN'(INC);
   assign w_seq = (WRAP_EN && (w_inc >= WRAP_LIMIT))
                ? RESET_VECTOR : w_inc;

   // A halt request in RUN holds the PC just like HALT itself,
   // so a target arriving with it is buffered.
   assign w_frozen = (r_state == S_HALT) ||
                     ((r_state == S_RUN) &&
                      (bus.stall_i || bus.halt_i));

   assign bus.pc_o          = r_pc;
   assign bus.pc_plus_inc_o = w_inc;
   assign bus.fetch_valid_o = r_fv;
   assign bus.misaligned_o  = r_mis;

   // Next state, next PC and pending-buffer update.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_mis_nxt   = 1'b0;
      w_pv_nxt    = r_pv;
      w_pt_nxt    = r_pt;
      w_ptrap_nxt = r_ptrap;
      w_apply     = 1'b0;
      w_tgt       = '0;
      unique case (r_state)
         S_BOOT: w_state_nxt = S_RUN;
         S_RUN, S_HALT: begin
            w_state_nxt = bus.halt_i ? S_HALT : S_RUN;
            if (bus.trap_valid_i) begin
               if (w_frozen) begin
                  w_pv_nxt    = 1'b1;
                  w_pt_nxt    = bus.trap_vector_i;
                  w_ptrap_nxt = 1'b1;
               end else begin
                  w_apply  = 1'b1;
                  w_tgt    = bus.trap_vector_i;
                  w_pv_nxt = 1'b0;
               end
            end else if (bus.redirect_valid_i) begin
               if (w_frozen) begin
                  if (!(r_pv && r_ptrap)) begin
                     w_pv_nxt    = 1'b1;
                     w_pt_nxt    = bus.redirect_target_i;
                     w_ptrap_nxt = 1'b0;
                  end
               end else begin
                  w_apply  = 1'b1;
                  w_tgt    = bus.redirect_target_i;
                  w_pv_nxt = 1'b0;
               end
            end else if (r_pv && !w_frozen) begin
               w_apply  = 1'b1;
               w_tgt    = r_pt;
               w_pv_nxt = 1'b0;
            end else if (!w_frozen) begin
               w_pc_nxt = w_seq;
            end
         end
         default: w_state_nxt = S_BOOT;
      endcase
      if (w_apply) begin
         w_pc_nxt  = w_tgt & ~LOW_MASK;
         w_mis_nxt = |(w_tgt & LOW_MASK);
      end
   end

   // State, PC, status and pending registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_BOOT;
         r_pc    <= RESET_VECTOR;
         r_fv    <= 1'b0;
         r_mis   <= 1'b0;
         r_pv    <= 1'b0;
         r_pt    <= '0;
         r_ptrap <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_fv    <= (w_state_nxt == S_RUN);
         r_mis   <= w_mis_nxt;
         r_pv    <= w_pv_nxt;
         r_pt    <= w_pt_nxt;
         r_ptrap <= w_ptrap_nxt;
      end
   end
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen.
// Main instance plus a wrapping instance.
module tb_pc_gen;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   pc_gen_if #(.XLEN(64)) m_if ();
   pc_gen_if #(.XLEN(64)) w_if ();

   pc_gen u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (m_if)
   );

   pc_gen #(
      .WRAP_EN    (1'b1),
      .WRAP_LIMIT (64'h10)
   ) u_wrap (
      .clk   (clk),
      .reset (reset),
      .bus   (w_if)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      m_if.stall_i           = 1'b0;
      m_if.halt_i            = 1'b0;
      m_if.redirect_valid_i  = 1'b0;
      m_if.redirect_target_i = '0;
      m_if.trap_valid_i      = 1'b0;
      m_if.trap_vector_i     = '0;
   endtask

   task automatic redir(input logic [63:0] t);
      m_if.redirect_valid_i  = 1'b1;
      m_if.redirect_target_i = t;
   endtask

   task automatic trap(input logic [63:0] t);
      m_if.trap_valid_i  = 1'b1;
      m_if.trap_vector_i = t;
   endtask

   task automatic chk_m(input string tag,
                        input logic [63:0] pc,
                        input logic fv,
                        input logic mis);
      check({tag, ".pc"}, m_if.pc_o, pc);
      check({tag, ".fv"}, 64'(m_if.fetch_valid_o), 64'(fv));
      check({tag, ".mis"}, 64'(m_if.misaligned_o), 64'(mis));
   endtask

   task automatic chk_w(input string tag,
                        input logic [63:0] pc);
      check({tag, ".wpc"}, w_if.pc_o, pc);
      check({tag, ".wmis"}, 64'(w_if.misaligned_o), 64'd0);
   endtask

   initial begin
      logic [63:0] wexp [6];
      wexp = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h0, 64'h4};
      idle();
      w_if.stall_i           = 1'b0;
      w_if.halt_i            = 1'b0;
      w_if.redirect_valid_i  = 1'b0;
      w_if.redirect_target_i = '0;
      w_if.trap_valid_i      = 1'b0;
      w_if.trap_vector_i     = '0;

      reset = 1'b1;
      tick();
      chk_m("rst", 64'h0, 1'b0, 1'b0);
      check("rst.wfv", 64'(w_if.fetch_valid_o), 64'd0);
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         tick();
         chk_m("seq", 64'(i * 4), 1'b1, 1'b0);
         chk_w("wrap", wexp[i]);
      end

      redir(64'h80);
      tick();
      idle();
      chk_m("redir", 64'h80, 1'b1, 1'b0);
      chk_w("wrap5", wexp[5]);
      tick();
      chk_m("redir+1", 64'h84, 1'b1, 1'b0);
      check("plus_inc", m_if.pc_plus_inc_o, 64'h88);

      trap(64'h200);
      redir(64'h300);
      tick();
      idle();
      chk_m("trapwin", 64'h200, 1'b1, 1'b0);

      redir(64'h20);
      tick();
      idle();
      m_if.stall_i = 1'b1;
      tick();
      chk_m("stall1", 64'h20, 1'b1, 1'b0);
      redir(64'h100);
      tick();
      chk_m("stall2", 64'h20, 1'b1, 1'b0);
      m_if.redirect_valid_i = 1'b0;
      trap(64'h300);
      tick();
      idle();
      chk_m("stall3", 64'h20, 1'b1, 1'b0);
      tick();
      chk_m("release", 64'h300, 1'b1, 1'b0);
      tick();
      chk_m("release+1", 64'h304, 1'b1, 1'b0);

      redir(64'h102);
      tick();
      idle();
      chk_m("misal", 64'h100, 1'b1, 1'b1);
      tick();
      chk_m("misal+1", 64'h104, 1'b1, 1'b0);

      m_if.stall_i = 1'b1;
      trap(64'h401);
      tick();
      chk_m("ptrap", 64'h104, 1'b1, 1'b0);
      m_if.trap_valid_i = 1'b0;
      redir(64'h500);
      tick();
      idle();
      chk_m("pkeep", 64'h104, 1'b1, 1'b0);
      tick();
      chk_m("papply", 64'h400, 1'b1, 1'b1);

      redir(64'hFFFF_FFFF_FFFF_FFFC);
      tick();
      idle();
      check("ovf.inc", m_if.pc_plus_inc_o, 64'h0);
      tick();
      chk_m("ovf", 64'h0, 1'b1, 1'b0);

      redir(64'h8);
      tick();
      idle();
      m_if.halt_i = 1'b1;
      tick();
      chk_m("halt", 64'h8, 1'b0, 1'b0);
      redir(64'h40);
      tick();
      m_if.redirect_valid_i = 1'b0;
      chk_m("haltcap", 64'h8, 1'b0, 1'b0);
      m_if.halt_i = 1'b0;
      tick();
      chk_m("unhalt", 64'h8, 1'b1, 1'b0);
      tick();
      chk_m("resume", 64'h40, 1'b1, 1'b0);
      tick();
      chk_m("resume+1", 64'h44, 1'b1, 1'b0);

      m_if.halt_i = 1'b1;
      redir(64'h60);
      tick();
      idle();
      chk_m("haltredir", 64'h44, 1'b0, 1'b0);
      tick();
      chk_m("haltredir2", 64'h44, 1'b1, 1'b0);
      tick();
      chk_m("haltredir3", 64'h60, 1'b1, 1'b0);

      m_if.stall_i = 1'b1;
      redir(64'h700);
      tick();
      m_if.redirect_valid_i = 1'b0;
      chk_m("pend700", 64'h60, 1'b1, 1'b0);
      reset = 1'b1;
      tick();
      chk_m("midrst", 64'h0, 1'b0, 1'b0);
      reset = 1'b0;
      tick();
      chk_m("boot", 64'h0, 1'b1, 1'b0);
      tick();
      chk_m("rststall", 64'h0, 1'b1, 1'b0);
      m_if.stall_i = 1'b0;
      tick();
      chk_m("nopend", 64'h4, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
